// File: rtl/zb_chip_spreader_if.sv
// ============================================================================
//  Module   : zb_chip_spreader_if
//  Purpose  : FIFO-side and modulator-side signals of the 802.15.4 spreader.
//             Optional I/Q ports appear when ZB_OQPSK_IQ_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface zb_chip_spreader_if;
    logic       inEnable;
    logic       inChipTick;
    logic       inFifoEmpty;
    logic [3:0] inSymbol;
    logic       outReadEnable;
    logic       outChip;
    logic       outChipValid;
    logic [4:0] outChipIndex;
    logic       outSymbolDone;
    logic       outBusy;
`ifdef ZB_OQPSK_IQ_EN
    logic       outChipI;
    logic       outChipQ;
`endif

    modport master (
        output inEnable, inChipTick, inFifoEmpty, inSymbol,
        input  outReadEnable, outChip, outChipValid, outChipIndex,
               outSymbolDone, outBusy
`ifdef ZB_OQPSK_IQ_EN
        , input outChipI, outChipQ
`endif
    );

    modport slave (
        input  inEnable, inChipTick, inFifoEmpty, inSymbol,
        output outReadEnable, outChip, outChipValid, outChipIndex,
               outSymbolDone, outBusy
`ifdef ZB_OQPSK_IQ_EN
        , output outChipI, outChipQ
`endif
    );
endinterface

`default_nettype wire

// File: rtl/zb_chip_spreader.sv
// ============================================================================
//  Module   : zb_chip_spreader
//  Purpose  : 802.15.4 2.4 GHz DSSS spreader: pops 4-bit symbols, emits 32
//             PN chips per symbol with next-symbol prefetch for gapless frames.
//             Define ZB_OQPSK_IQ_EN to add the offset I/Q chip outputs.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module zb_chip_spreader #(
    parameter int CHIP_COUNT    = 32,
    parameter int PREFETCH_CHIP = 16,
    parameter int FIFO_RD_LAT   = 1
) (
    input  wire logic          inClock,
    input  wire logic          inReset,
    zb_chip_spreader_if.slave  bus
);

    localparam logic [4:0] c_LAST_IDX     = 5'(CHIP_COUNT - 1);
    localparam logic [4:0] c_PREFETCH_IDX = 5'(PREFETCH_CHIP);
    localparam logic [1:0] c_RD_LAT       = 2'(FIFO_RD_LAT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SPREAD = 2'd2
    } state_t;

    // Chip words hold c0 in bit 31 so chip idx is word[31-idx].
    function automatic logic [31:0] f_chip_word(input logic [3:0] sym);
        case (sym)
            4'h0:    return 32'hD9C3_522E;
            4'h1:    return 32'hED9C_3522;
            4'h2:    return 32'h2ED9_C352;
            4'h3:    return 32'h22ED_9C35;
            4'h4:    return 32'h522E_D9C3;
            4'h5:    return 32'h3522_ED9C;
            4'h6:    return 32'hC352_2ED9;
            4'h7:    return 32'h9C35_22ED;
            4'h8:    return 32'h8C96_077B;
            4'h9:    return 32'hB8C9_6077;
            4'hA:    return 32'h7B8C_9607;
            4'hB:    return 32'h77B8_C960;
            4'hC:    return 32'h077B_8C96;
            4'hD:    return 32'h6077_B8C9;
            4'hE:    return 32'h9607_7B8C;
            default: return 32'hC960_77B8;
        endcase
    endfunction

    state_t      r_state;
    logic [31:0] r_word;
    logic [31:0] r_pend_word;
    logic        r_pend;
    logic [4:0]  r_idx;
    logic        r_rd_fl;
    logic [1:0]  r_rd_cnt;
    logic        r_rd_en;
    logic        r_chip;
    logic        r_valid;
    logic [4:0]  r_index;
    logic        r_done;
    logic        r_busy;
`ifdef ZB_OQPSK_IQ_EN
    logic        r_chip_i;
    logic        r_chip_q;
`endif

    logic w_can_read;
    logic w_rd_data;

    assign w_can_read = bus.inEnable & ~bus.inFifoEmpty;
    assign w_rd_data  = r_rd_fl & (r_rd_cnt == c_RD_LAT);

    always_ff @(posedge inClock) begin
        if (inReset) begin
            r_state     <= ST_IDLE;
            r_word      <= '0;
            r_pend_word <= '0;
            r_pend      <= 1'b0;
            r_idx       <= '0;
            r_rd_fl     <= 1'b0;
            r_rd_cnt    <= '0;
            r_rd_en     <= 1'b0;
            r_chip      <= 1'b0;
            r_valid     <= 1'b0;
            r_index     <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
`ifdef ZB_OQPSK_IQ_EN
            r_chip_i    <= 1'b0;
            r_chip_q    <= 1'b0;
`endif
        end else begin
            r_rd_en <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;

            // One read in flight at most; the counter marks when inSymbol is valid.
            if (r_rd_fl) begin
                if (w_rd_data)
                    r_rd_fl <= 1'b0;
                else
                    r_rd_cnt <= r_rd_cnt + 2'd1;
            end

`ifdef ZB_OQPSK_IQ_EN
            if (bus.inChipTick && r_state != ST_SPREAD) begin
                r_chip_i <= 1'b0;
                r_chip_q <= 1'b0;
            end
`endif

            case (r_state)
                ST_IDLE: begin
                    if (w_can_read) begin
                        r_rd_en  <= 1'b1;
                        r_rd_fl  <= 1'b1;
                        r_rd_cnt <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_rd_data) begin
                        r_word  <= f_chip_word(bus.inSymbol);
                        r_idx   <= '0;
                        r_state <= ST_SPREAD;
                    end
                end
                ST_SPREAD: begin
                    if (w_rd_data) begin
                        r_pend_word <= f_chip_word(bus.inSymbol);
                        r_pend      <= 1'b1;
                    end
                    if (bus.inChipTick) begin
                        r_chip  <= r_word[~r_idx];
                        r_index <= r_idx;
                        r_valid <= 1'b1;
                        r_idx   <= r_idx + 5'd1;
`ifdef ZB_OQPSK_IQ_EN
                        if (r_idx[0])
                            r_chip_q <= r_word[~r_idx];
                        else
                            r_chip_i <= r_word[~r_idx];
`endif
                        if (r_idx == c_PREFETCH_IDX && w_can_read && !r_pend && !r_rd_fl) begin
                            r_rd_en  <= 1'b1;
                            r_rd_fl  <= 1'b1;
                            r_rd_cnt <= '0;
                        end
                        if (r_idx == c_LAST_IDX) begin
                            r_done <= 1'b1;
                            r_idx  <= '0;
                            // Data arriving on the final tick bypasses the pending register.
                            if (r_pend) begin
                                r_word <= r_pend_word;
                                r_pend <= 1'b0;
                            end else if (w_rd_data) begin
                                r_word <= f_chip_word(bus.inSymbol);
                                r_pend <= 1'b0;
                            end else if (r_rd_fl) begin
                                r_state <= ST_WAIT;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.outReadEnable = r_rd_en;
    assign bus.outChip       = r_chip;
    assign bus.outChipValid  = r_valid;
    assign bus.outChipIndex  = r_index;
    assign bus.outSymbolDone = r_done;
    assign bus.outBusy       = r_busy;
`ifdef ZB_OQPSK_IQ_EN
    assign bus.outChipI      = r_chip_i;
    assign bus.outChipQ      = r_chip_q;
`endif

endmodule

`default_nettype wire
